// File: rtl/req_ack_scheduler.sv
// Round-robin arbiter sharing one req/ack responder between N_REQ clients,
// with a bounded ack window that ends in either a valid or an error pulse.
module req_ack_scheduler #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_in,
    output logic [N_REQ-1:0]  grant,
    output logic              req,
    input  logic              ack,
    input  logic [DATA_W-1:0] data,
    output logic              valid,
    output logic [DATA_W-1:0] data_out,
    output logic              error,
    output logic              busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] TOUT = 2'd3;

    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] pick;
    logic [PW:0]   sum;
    logic [CW-1:0] cnt;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        pick = '0;
        sum  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (PW + 1)'(i);
            if (sum >= (PW + 1)'(N_REQ))
                sum = sum - (PW + 1)'(N_REQ);
            if (req_in[sum[PW-1:0]])
                pick = sum[PW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            req      <= 1'b0;
            valid    <= 1'b0;
            error    <= 1'b0;
            data_out <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            owner    <= '0;
            cnt      <= '0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req_in) begin
                        state <= REQ;
                        owner <= pick;
                        grant <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                        req   <= 1'b1;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                REQ: begin
                    // Ack in the very first REQ cycle (cnt==0) is outside the window.
                    if (ack && cnt != '0) begin
                        data_out <= data;
                        valid    <= 1'b1;
                        req      <= 1'b0;
                        state    <= RESP;
                    end else if (cnt == CW'(MAX_WAIT)) begin
                        error <= 1'b1;
                        req   <= 1'b0;
                        state <= TOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP, TOUT: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                    ptr   <= (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_req_ack_scheduler.sv
// Directed, table-driven bench for req_ack_scheduler with a few
// hand-written sequences around asynchronous reset.
module tb_req_ack_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_in;
    logic [3:0] grant;
    logic       req;
    logic       ack;
    logic [7:0] data;
    logic       valid;
    logic [7:0] data_out;
    logic       error;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    req_ack_scheduler #(.N_REQ(4), .DATA_W(8), .MAX_WAIT(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_in   (req_in),
        .grant    (grant),
        .req      (req),
        .ack      (ack),
        .data     (data),
        .valid    (valid),
        .data_out (data_out),
        .error    (error),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req_in;
        logic       ack;
        logic [7:0] data;
        logic [3:0] grant;
        logic       req;
        logic       valid;
        logic       error;
        logic [7:0] dout;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic [3:0] ri, logic a, logic [7:0] d,
                                logic [3:0] g, logic rq, logic v, logic e,
                                logic [7:0] dout, logic b);
        vec_t x;
        x.rst_n = r;  x.req_in = ri; x.ack = a;   x.data = d;
        x.grant = g;  x.req = rq;    x.valid = v; x.error = e;
        x.dout = dout; x.busy = b;
        tbl.push_back(x);
    endfunction

    task automatic expect_out(string name, logic [3:0] g, logic rq, logic v,
                              logic e, logic [7:0] d, logic b);
        checks++;
        if (grant !== g || req !== rq || valid !== v || error !== e ||
            data_out !== d || busy !== b) begin
            failures++;
            $display("FAIL %s: got grant=%b req=%b valid=%b error=%b data_out=%h busy=%b, want grant=%b req=%b valid=%b error=%b data_out=%h busy=%b",
                     name, grant, req, valid, error, data_out, busy,
                     g, rq, v, e, d, b);
        end
    endtask

    // Invariants checked every cycle away from the active edge.
    always @(negedge clk) begin
        checks++;
        if (valid && error) begin
            failures++;
            $display("FAIL inv_valid_error: valid=%b error=%b, want not both 1", valid, error);
        end
        checks++;
        if (req && grant == 4'b0000) begin
            failures++;
            $display("FAIL inv_req_grant: req=%b grant=%b, want grant!=0 when req=1", req, grant);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t, want finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] g;
        logic [7:0] pd;
        logic [7:0] d;

        rst_n  = 1'b0;
        req_in = 4'b0000;
        ack    = 1'b0;
        data   = 8'h00;
        #1;
        expect_out("reset_state", 4'b0000, 0, 0, 0, 8'h00, 0);
        @(posedge clk);
        #1;
        expect_out("reset_held", 4'b0000, 0, 0, 0, 8'h00, 0);

        // Single access, ack at t+2 (ack at t ignored)
        add(1, 4'b0001, 0, 8'h00, 4'b0001, 1, 0, 0, 8'h00, 1);
        add(1, 4'b0001, 1, 8'h33, 4'b0001, 1, 0, 0, 8'h00, 1);
        add(1, 4'b0001, 0, 8'h00, 4'b0001, 1, 0, 0, 8'h00, 1);
        add(1, 4'b0001, 1, 8'hA5, 4'b0001, 0, 1, 0, 8'hA5, 1);
        add(1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0, 8'hA5, 0);
        // Timeout with no ack
        add(1, 4'b0010, 0, 8'h00, 4'b0010, 1, 0, 0, 8'hA5, 1);
        for (int i = 0; i < 5; i++)
            add(1, 4'b0010, 0, 8'h00, 4'b0010, 1, 0, 0, 8'hA5, 1);
        add(1, 4'b0010, 0, 8'h00, 4'b0010, 0, 0, 1, 8'hA5, 1);
        add(1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0, 8'hA5, 0);
        // Ack at the last window cycle t+5
        add(1, 4'b0100, 0, 8'h00, 4'b0100, 1, 0, 0, 8'hA5, 1);
        for (int i = 0; i < 5; i++)
            add(1, 4'b0100, 0, 8'h00, 4'b0100, 1, 0, 0, 8'hA5, 1);
        add(1, 4'b0100, 1, 8'h5C, 4'b0100, 0, 1, 0, 8'h5C, 1);
        add(1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0, 8'h5C, 0);
        // Ack only at t is a timeout
        add(1, 4'b1000, 0, 8'h00, 4'b1000, 1, 0, 0, 8'h5C, 1);
        add(1, 4'b1000, 1, 8'h77, 4'b1000, 1, 0, 0, 8'h5C, 1);
        for (int i = 0; i < 4; i++)
            add(1, 4'b1000, 0, 8'h00, 4'b1000, 1, 0, 0, 8'h5C, 1);
        add(1, 4'b1000, 0, 8'h00, 4'b1000, 0, 0, 1, 8'h5C, 1);
        add(1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0, 8'h5C, 0);
        // Stray ack/data while idle
        add(1, 4'b0000, 1, 8'hEE, 4'b0000, 0, 0, 0, 8'h5C, 0);
        add(1, 4'b0000, 1, 8'hEE, 4'b0000, 0, 0, 0, 8'h5C, 0);
        // Withdrawal at t+1, ack at t+3
        add(1, 4'b0001, 0, 8'h00, 4'b0001, 1, 0, 0, 8'h5C, 1);
        add(1, 4'b0001, 0, 8'h00, 4'b0001, 1, 0, 0, 8'h5C, 1);
        add(1, 4'b0000, 0, 8'h00, 4'b0001, 1, 0, 0, 8'h5C, 1);
        add(1, 4'b0000, 0, 8'h00, 4'b0001, 1, 0, 0, 8'h5C, 1);
        add(1, 4'b0000, 1, 8'hC3, 4'b0001, 0, 1, 0, 8'hC3, 1);
        add(1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0, 8'hC3, 0);
        // Reset, then round robin with all requesters held
        add(0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0, 8'h00, 0);
        pd = 8'h00;
        for (int n = 0; n < 5; n++) begin
            g = 4'b0001 << (n % 4);
            d = 8'h10 + 8'(n);
            add(1, 4'b1111, 0, 8'h00, g, 1, 0, 0, pd, 1);
            add(1, 4'b1111, 0, 8'h00, g, 1, 0, 0, pd, 1);
            add(1, 4'b1111, 1, d, g, 0, 1, 0, d, 1);
            add(1, 4'b1111, 0, 8'h00, 4'b0000, 0, 0, 0, d, 0);
            pd = d;
        end
        // Leaves the pointer at 2 ahead of the reset test
        add(1, 4'b0010, 0, 8'h00, 4'b0010, 1, 0, 0, 8'h14, 1);
        add(1, 4'b0010, 0, 8'h00, 4'b0010, 1, 0, 0, 8'h14, 1);
        add(1, 4'b0010, 1, 8'h3C, 4'b0010, 0, 1, 0, 8'h3C, 1);
        add(1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 0, 8'h3C, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n  = tbl[i].rst_n;
            req_in = tbl[i].req_in;
            ack    = tbl[i].ack;
            data   = tbl[i].data;
            @(posedge clk);
            #1;
            expect_out($sformatf("vec%0d", i), tbl[i].grant, tbl[i].req,
                       tbl[i].valid, tbl[i].error, tbl[i].dout, tbl[i].busy);
        end

        // Reset during REQ at t+2
        rst_n = 1'b1; req_in = 4'b0100; ack = 1'b0; data = 8'h00;
        @(posedge clk); #1;
        expect_out("rst_mid_t", 4'b0100, 1, 0, 0, 8'h3C, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        expect_out("rst_mid_t2", 4'b0100, 1, 0, 0, 8'h3C, 1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst_mid_async", 4'b0000, 0, 0, 0, 8'h00, 0);
        ack = 1'b1; data = 8'h99;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            expect_out($sformatf("rst_mid_hold%0d", i), 4'b0000, 0, 0, 0, 8'h00, 0);
        end
        rst_n = 1'b1; req_in = 4'b1010; ack = 1'b0; data = 8'h00;
        @(posedge clk); #1;
        expect_out("rst_regrant", 4'b0010, 1, 0, 0, 8'h00, 1);
        @(posedge clk); #1;
        ack = 1'b1; data = 8'h6B;
        @(posedge clk); #1;
        ack = 1'b0;
        expect_out("rst_regrant_done", 4'b0010, 0, 1, 0, 8'h6B, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
